rvc_fifo: RTL and testbench

- Parametrised ready/valid channel controller: the next generation of rvc.
- Owns its own storage instead of driving an external 1-bit mod_register.
- Buffers DEPTH words of WIDTH bits between an upstream valid/ready producer and a downstream valid/ready consumer.
- Optional same-cycle bypass when empty; exposes occupancy for flow-control debug.

---
 rtl/rvc_fifo.sv | 78 +++++++
 tb/tb_rvc_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_fifo.sv
// rvc_fifo: ready/valid FIFO with its own storage. It holds DEPTH words of
// WIDTH bits between a valid/ready producer and a valid/ready consumer.
// When BYPASS=1 and the queue is empty, a word can pass straight through
// from in_data to out_data in the same cycle without being stored.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready back to in_ready.
module rvc_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  // Pointer width. A single-entry queue still gets a 1-bit pointer, which
  // always stays at 0.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam bit BYP = (BYPASS != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             thru;

  // Advance a pointer modulo DEPTH. DEPTH need not be a power of two, so an
  // explicit compare is used instead of masking.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Flags and handshake outputs, decoded from the registered count
  always_comb begin
    empty     = (count == '0);
    full      = (count == DEPTH_C);
    in_ready  = !full;
    out_valid = BYP ? (!empty || in_valid) : !empty;
    out_data  = (BYP && empty) ? in_data : mem[rd_ptr];
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    // With the queue empty, a pop can only be the bypassed input word.
    thru      = BYP && empty && push && pop;
  end

  // Storage write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (push && !thru) mem[wr_ptr] <= in_data;
  end

  // Pointers and occupancy; a bypass transfer leaves all of them unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && !thru) wr_ptr <= next_ptr(wr_ptr);
      if (pop && !thru)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_rvc_fifo.sv
// Testbench for rvc_fifo. It uses three instances:
//   u_a : DEPTH=4, BYPASS=0 (reset, fill, full-pop rule, async reset)
//   u_b : DEPTH=3, BYPASS=0 (pointer wrap under a toggling consumer)
//   u_c : DEPTH=4, BYPASS=1 (same-cycle bypass)
// Drivers push each expected word into a per-instance queue when they first
// present it. Monitors sample at negedge, and on every handshake they pop the
// queue and compare the value against out_data.
module tb_rvc_fifo;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_full, a_empty;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_count;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_full, b_empty;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_count;
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_full, c_empty;
  logic [7:0] c_in_data, c_out_data;
  logic [2:0] c_count;

  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic [7:0] qc [$];
  int pa, pb, pc;

  rvc_fifo #(.WIDTH(8), .DEPTH(4), .BYPASS(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .count(a_count), .full(a_full), .empty(a_empty));

  rvc_fifo #(.WIDTH(8), .DEPTH(3), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .count(b_count), .full(b_full), .empty(b_empty));

  rvc_fifo #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .count(c_count), .full(c_full), .empty(c_empty));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_in_ready"}, 32'(a_in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(a_out_valid), 32'd0);
    chk({tag, "_count"}, 32'(a_count), 32'd0);
    chk({tag, "_empty"}, 32'(a_empty), 32'd1);
    chk({tag, "_full"}, 32'(a_full), 32'd0);
  endtask

  // Scoreboard monitors: a handshake seen mid-cycle completes at the next edge
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      pa++;
      if (qa.size() == 0) chk("a_unexpected_word", 32'(a_out_data), 32'hFFFF_FFFF);
      else chk("a_out_data", 32'(a_out_data), 32'(qa.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      pb++;
      if (qb.size() == 0) chk("b_unexpected_word", 32'(b_out_data), 32'hFFFF_FFFF);
      else chk("b_out_data", 32'(b_out_data), 32'(qb.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && c_out_valid && c_out_ready) begin
      pc++;
      if (qc.size() == 0) chk("c_unexpected_word", 32'(c_out_data), 32'hFFFF_FFFF);
      else chk("c_out_data", 32'(c_out_data), 32'(qc.pop_front()));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fill_words [4];
    logic       acc;
    int         idx;
    int         maxc;
    logic       saw_full;

    checks = 0; errors = 0; pa = 0; pb = 0; pc = 0;
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
    fill_words[0] = 8'h11; fill_words[1] = 8'h22;
    fill_words[2] = 8'h33; fill_words[3] = 8'h44;

    // Reset, then three idle clocks
    #1;
    chk_idle_a("rst");
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) begin
      step();
      chk_idle_a("idle");
    end

    // Fill to full with the consumer stalled
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = fill_words[i];
      qa.push_back(fill_words[i]);
      step();
      chk("fill_count", 32'(a_count), 32'(i + 1));
    end
    chk("fill_full", 32'(a_full), 32'd1);
    chk("fill_in_ready", 32'(a_in_ready), 32'd0);
    a_in_data = 8'h55;
    qa.push_back(8'h55);
    step();
    chk("held_count", 32'(a_count), 32'd4);
    chk("held_in_ready", 32'(a_in_ready), 32'd0);

    // Drain from full: the first pop must not let 0x55 in on the same edge
    a_out_ready = 1'b1;
    step();
    chk("fullpop_count", 32'(a_count), 32'd3);
    chk("fullpop_in_ready", 32'(a_in_ready), 32'd1);
    step();
    chk("push55_count", 32'(a_count), 32'd3);
    a_in_valid = 1'b0;
    for (int i = 0; i < 20 && !a_empty; i++) step();
    chk("a_drain_empty", 32'(a_empty), 32'd1);
    chk("a_drain_queue", 32'(qa.size()), 32'd0);
    chk("a_drain_pops", 32'(pa), 32'd5);
    a_out_ready = 1'b0;

    // DEPTH=3 stream of ten words with out_ready toggling 1,0,1,0
    idx = 0; maxc = 0; saw_full = 1'b0;
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h00;
    qb.push_back(8'h00);
    for (int cyc = 0; cyc < 200 && (idx < 10 || qb.size() != 0); cyc++) begin
      @(negedge clk);
      acc = b_in_valid && b_in_ready;
      step();
      if (int'(b_count) > maxc) maxc = int'(b_count);
      if (b_full) saw_full = 1'b1;
      if (acc) begin
        idx++;
        if (idx < 10) begin
          b_in_data = 8'(idx);
          qb.push_back(8'(idx));
        end else begin
          b_in_valid = 1'b0;
        end
      end
      b_out_ready = ~b_out_ready;
    end
    chk("b_accepted", 32'(idx), 32'd10);
    chk("b_queue_left", 32'(qb.size()), 32'd0);
    chk("b_pops", 32'(pb), 32'd10);
    chk("b_count_le_3", 32'(maxc <= 3), 32'd1);
    chk("b_reached_full", 32'(saw_full), 32'd1);
    chk("b_end_empty", 32'(b_empty), 32'd1);
    b_out_ready = 1'b0;

    // Bypass: an empty queue passes the word through in the same cycle
    step();
    c_in_valid = 1'b1; c_in_data = 8'hA5; c_out_ready = 1'b1;
    qc.push_back(8'hA5);
    #1;
    chk("byp_out_valid", 32'(c_out_valid), 32'd1);
    chk("byp_out_data", 32'(c_out_data), 32'hA5);
    step();
    chk("byp_count", 32'(c_count), 32'd0);
    chk("byp_empty", 32'(c_empty), 32'd1);
    // Bypass with a stalled consumer: the word is stored instead
    c_in_data = 8'h3C; c_out_ready = 1'b0;
    qc.push_back(8'h3C);
    step();
    chk("byp_store_count", 32'(c_count), 32'd1);
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    #1;
    chk("byp_mem_data", 32'(c_out_data), 32'h3C);
    step();
    chk("byp_pop_count", 32'(c_count), 32'd0);
    c_out_ready = 1'b0;
    chk("c_pops", 32'(pc), 32'd2);

    // Async reset mid-stream on u_a
    a_in_valid = 1'b1; a_in_data = 8'h01;
    qa.push_back(8'h01);
    step();
    a_in_data = 8'h02;
    qa.push_back(8'h02);
    step();
    a_in_valid = 1'b0;
    chk("pre_rst_count", 32'(a_count), 32'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_idle_a("async_rst");
    qa.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    step();
    a_in_valid = 1'b1; a_in_data = 8'h77; a_out_ready = 1'b1;
    qa.push_back(8'h77);
    pa = 0;
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 10 && qa.size() != 0; i++) step();
    chk("post_rst_queue", 32'(qa.size()), 32'd0);
    chk("post_rst_pops", 32'(pa), 32'd1);
    chk("post_rst_empty", 32'(a_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
